dmem_responder: RTL

- Data-memory responder: the far end of the load/store bus driven by the execute stage (command, size, address, data).
- Accepts at most one request per cycle and performs stores at acceptance.
- Each accepted request returns a nonzero transaction tag in the same cycle.
- Load data comes back a fixed LATENCY cycles later, tagged for matching by the completion logic.
- Serves as the cycle-accurate Dmem model for the out-of-order core and its testbenches.

---
 rtl/dmem_responder_pkg.sv | 44 ++++
 rtl/dmem_responder_lane_align.sv | 61 ++++++
 rtl/dmem_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared load/store bus definitions: bus command and access-size encodings,
//   the tagged response packet carried through the load-latency pipeline and
//   handed to the completion logic, and a helper for alignment checks.
//   No ports (package).
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   // DOUBLE is the reserved encoding on a 32-bit bus; requests using it are refused.
   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } DMEM_RESP_PACKET;

   // True when the byte offset is not a multiple of the access size.
   function automatic logic is_misaligned(input MEM_SIZE size, input logic [1:0] offset);
      logic result;
      result = 1'b0;
      case (size)
         HALF:    result = offset[0];
         WORD:    result = |offset;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
//   Combinational byte-lane alignment shared by the data-memory responder and
//   the LSQ forwarding path.
//     Extract: shifts a memory word right by offset*8 and zero-extends it to
//              the access size (sign extension belongs to the load unit).
//     Merge:   shifts right-justified store data into its lanes and produces
//              the matching byte enables.
//   Ports:
//     i_size        access size (MEM_SIZE encoding)
//     i_offset      byte offset within the word (addr[1:0])
//     i_rdata       memory word being loaded from
//     i_wdata       right-justified store data
//     o_load_data   aligned, zero-extended load result
//     o_byte_en     per-lane write enables for the store
//     o_wdata_lane  store data placed in its byte lanes
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [1:0]      i_size,
   input  logic [1:0]      i_offset,
   input  logic [XLEN-1:0] i_rdata,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_load_data,
   output logic [3:0]      o_byte_en,
   output logic [XLEN-1:0] o_wdata_lane
);

   logic [4:0]      w_shamt;
   logic [XLEN-1:0] w_shifted;

   assign w_shamt      = {i_offset, 3'b000};
   assign w_shifted    = i_rdata >> w_shamt;
   assign o_wdata_lane = i_wdata << w_shamt;

   always_comb begin
      // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
      o_load_data = '0;
      o_byte_en   = 4'b0000;
      case (MEM_SIZE'(i_size))
         BYTE: begin
            o_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            o_byte_en   = 4'b0001 << i_offset;
         end
         HALF: begin
            o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            o_byte_en   = i_offset[1] ? 4'b1100 : 4'b0011;
         end
         WORD: begin
            o_load_data = w_shifted;
            o_byte_en   = 4'b1111;
         end
         default: begin
            o_load_data = '0;
            o_byte_en   = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Cycle-accurate data-memory model at the far end of the load/store bus.
//   One request per cycle; stores merge at the acceptance edge; loads read at
//   acceptance and return {tag, data} LATENCY cycles later through a
//   fixed-length shift pipeline. Every accepted request receives a nonzero
//   tag in the same cycle; refused requests pulse Dmem2proc_error.
//   Ports:
//     clock               system clock, rising edge
//     reset               asynchronous, active-low reset
//     proc2Dmem_command   BUS_NONE / BUS_LOAD / BUS_STORE
//     proc2Dmem_size      BYTE / HALF / WORD (DOUBLE reserved)
//     proc2Dmem_addr      byte address
//     proc2Dmem_data      right-justified store data
//     Dmem2proc_response  tag for this cycle's request, 0 = refused/idle (comb)
//     Dmem2proc_tag       tag of returning load data, 0 = none (registered)
//     Dmem2proc_data      returning load data, zero-extended (registered)
//     Dmem2proc_error     refusal pulse (comb)
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4,    // 1..14, must stay below NUM_TAGS
   parameter int NUM_TAGS  = 15
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       proc2Dmem_command,
   input  logic [1:0]       proc2Dmem_size,
   input  logic [XLEN-1:0]  proc2Dmem_addr,
   input  logic [XLEN-1:0]  proc2Dmem_data,
   output logic [TAG_W-1:0] Dmem2proc_response,
   output logic [TAG_W-1:0] Dmem2proc_tag,
   output logic [XLEN-1:0]  Dmem2proc_data,
   output logic             Dmem2proc_error
);

   localparam int            ADDR_W    = $clog2(MEM_WORDS);
   localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(MEM_WORDS) << 2;

   BUS_COMMAND        w_cmd;
   MEM_SIZE           w_size;
   logic              w_misaligned;
   logic              w_out_of_range;
   logic              w_bad_size;
   logic              w_refuse;
   logic              w_accept;
   logic              w_load_accept;
   logic              w_store_accept;
   logic [ADDR_W-1:0] w_word_idx;
   logic [XLEN-1:0]   w_rdata;
   logic [XLEN-1:0]   w_load_data;
   logic [3:0]        w_byte_en;
   logic [XLEN-1:0]   w_wdata_lane;
   DMEM_RESP_PACKET   w_stage_in;

   logic [TAG_W-1:0]  r_tag;
   DMEM_RESP_PACKET   r_pipe [LATENCY];
   logic [XLEN-1:0]   r_mem  [MEM_WORDS];

   // ---------------- request qualification ----------------
   assign w_cmd          = BUS_COMMAND'(proc2Dmem_command);
   assign w_size         = MEM_SIZE'(proc2Dmem_size);
   assign w_misaligned   = is_misaligned(w_size, proc2Dmem_addr[1:0]);
   assign w_out_of_range = {1'b0, proc2Dmem_addr} >= MEM_BYTES;
   assign w_bad_size     = (w_size == DOUBLE);
   assign w_refuse       = (w_cmd != BUS_NONE) && (w_misaligned || w_out_of_range || w_bad_size);
   assign w_accept       = !w_refuse && ((w_cmd == BUS_LOAD) || (w_cmd == BUS_STORE));
   assign w_load_accept  = w_accept && (w_cmd == BUS_LOAD);
   assign w_store_accept = w_accept && (w_cmd == BUS_STORE);

   assign Dmem2proc_response = w_accept ? r_tag : '0;
   assign Dmem2proc_error    = w_refuse;

   // ---------------- memory array ----------------
   assign w_word_idx = proc2Dmem_addr[ADDR_W+1:2];
   assign w_rdata    = r_mem[w_word_idx];

   dmem_lane_align u_lane_align (
      .i_size       (proc2Dmem_size),
      .i_offset     (proc2Dmem_addr[1:0]),
      .i_rdata      (w_rdata),
      .i_wdata      (proc2Dmem_data),
      .o_load_data  (w_load_data),
      .o_byte_en    (w_byte_en),
      .o_wdata_lane (w_wdata_lane)
   );

   // NOTE: the memory array has no reset; its contents survive reset and it maps onto RAM.
   always_ff @(posedge clock) begin
      if (w_store_accept) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byte_en[b]) r_mem[w_word_idx][b*8 +: 8] <= w_wdata_lane[b*8 +: 8];
         end
      end
   end

   // ---------------- tag counter: 1..NUM_TAGS, never 0 ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tag <= TAG_W'(1);
      end else if (w_accept) begin
         r_tag <= (r_tag == TAG_W'(NUM_TAGS)) ? TAG_W'(1) : r_tag + 1'b1;
      end
   end

   // ---------------- load latency pipeline ----------------
   // Bubbles carry tag 0 with zero data so idle output is always clean.
   always_comb begin
      w_stage_in = '0;
      if (w_load_accept) begin
         w_stage_in.tag  = r_tag;
         w_stage_in.data = w_load_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_stage_in;
         for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign Dmem2proc_tag  = r_pipe[LATENCY-1].tag;
   assign Dmem2proc_data = r_pipe[LATENCY-1].data;

endmodule
